// File: rtl/dual_port_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dual_port_ram_fifo_ctrl
//
// Synchronous FIFO controller that drives an external dual_port_ram. It turns
// push/pop requests into RAM write/read cycles and keeps the read/write
// pointers, occupancy, status flags and sticky error flags. The words
// themselves live only in the external RAM. This block holds no data array.
//
// Handshake: wr_en and rd_en are requests. A request is accepted in a cycle
// when its flag allows it: a push is accepted when ~full, and a pop is
// accepted when ~empty. Both flags are the values seen before the edge.
// An accepted pop returns its word one cycle later on rd_data, qualified by
// rd_valid. There is no back-pressure on the read return path.
//
// Parameters
//   ADDR_SIZE  RAM address width
//   DATA_SIZE  data word width
//   DEPTH      RAM entries; must equal 2**ADDR_SIZE
//   AFULL_LVL  occupancy at or above which almost_full asserts (1..DEPTH)
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   wr_en, wr_data    push request and data
//   rd_en             pop request
//   clr_err           synchronous clear of overflow/underflow
//   rd_data, rd_valid popped word (passed through from the RAM) and strobe
//   full, empty       occupancy == DEPTH / occupancy == 0
//   almost_full       occupancy >= AFULL_LVL
//   count             occupancy, 0..DEPTH
//   overflow          sticky: push attempted while full
//   underflow         sticky: pop attempted while empty
//   ram_cs/we/re/oe   RAM controls
//   ram_wr_address    RAM write address
//   ram_rd_address    RAM read address
//   ram_data_in       RAM write data
//   ram_data_out      RAM read data, registered inside the RAM
// -----------------------------------------------------------------------------
module dual_port_ram_fifo_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic                 ram_re,
    output logic                 ram_oe,
    output logic [ADDR_SIZE-1:0] ram_wr_address,
    output logic [ADDR_SIZE-1:0] ram_rd_address,
    output logic [DATA_SIZE-1:0] ram_data_in,
    input  logic [DATA_SIZE-1:0] ram_data_out
);

    localparam logic [ADDR_SIZE:0] PTR_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] DEPTH_CNT = DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AFULL_CNT = AFULL_LVL[ADDR_SIZE:0];

    // -------------------------------------------------------------------------
    // State
    // The pointers are one bit wider than the RAM address. The extra MSB is
    // a wrap bit. It tells a full FIFO (same address, different lap) apart
    // from an empty one (same address, same lap).
    // -------------------------------------------------------------------------
    logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE:0] rd_ptr_q, rd_ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [ADDR_SIZE:0] count_w;
    logic               full_w;
    logic               empty_w;
    logic               push_ok;
    logic               pop_ok;

    // -------------------------------------------------------------------------
    // Flag decode from the registered pointers
    // -------------------------------------------------------------------------
    always_comb begin
        count_w = wr_ptr_q - rd_ptr_q;
        empty_w = (wr_ptr_q == rd_ptr_q);
        // Low bits equal with MSBs differing is the same condition as a
        // difference of exactly DEPTH.
        full_w  = (count_w == DEPTH_CNT);
    end

    // -------------------------------------------------------------------------
    // Accept decisions
    // These are gated by rst_n so that the RAM controls are 0 while reset is
    // held, even if a request input is high at that time.
    // -------------------------------------------------------------------------
    always_comb begin
        push_ok = rst_n & wr_en & ~full_w;
        pop_ok  = rst_n & rd_en & ~empty_w;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = pop_ok;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Clear first, then set. This order makes a set win when both
        // happen in the same cycle.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        full           = full_w;
        empty          = empty_w;
        count          = count_w;
        almost_full    = (count_w >= AFULL_CNT);
        overflow       = overflow_q;
        underflow      = underflow_q;
        rd_valid       = rd_valid_q;
        // The RAM registers its read data, so the word of a pop accepted in
        // cycle N is on ram_data_out in cycle N+1. rd_valid_q matches that.
        rd_data        = ram_data_out;

        ram_we         = push_ok;
        ram_re         = pop_ok;
        ram_oe         = pop_ok;
        ram_cs         = push_ok | pop_ok;
        ram_wr_address = wr_ptr_q[ADDR_SIZE-1:0];
        ram_rd_address = rd_ptr_q[ADDR_SIZE-1:0];
        ram_data_in    = wr_data;
    end

endmodule

// File: doc/dual_port_ram_fifo_ctrl.md
# dual_port_ram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of `dual_port_ram` and owns its address and enable generation. It converts push/pop requests into RAM write/read cycles and keeps read/write pointers, occupancy and full/empty status. It returns RAM read data to the consumer with a valid strobe. Storage lives entirely in the external `dual_port_ram` instance; this block holds no data array.

## Interface

Parameters:
- `ADDR_SIZE`, 4: RAM address width.
- `DATA_SIZE`, 8: data word width.
- `DEPTH`, 16: RAM entries; must equal 2**ADDR_SIZE.
- `AFULL_LVL`, 12: occupancy at or above which `almost_full` asserts; range 1..DEPTH.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: push request.
- `wr_data` in DATA_SIZE: push data.
- `rd_en` in 1: pop request.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `rd_data` out DATA_SIZE: popped word; equals `ram_data_out`.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `full` out 1: occupancy == DEPTH.
- `empty` out 1: occupancy == 0.
- `almost_full` out 1: occupancy >= AFULL_LVL.
- `count` out ADDR_SIZE+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a push was attempted while full.
- `underflow` out 1: sticky; a pop was attempted while empty.
- `ram_cs`, `ram_we`, `ram_re`, `ram_oe` out 1 each: RAM controls.
- `ram_wr_address`, `ram_rd_address` out ADDR_SIZE: RAM addresses.
- `ram_data_in` out DATA_SIZE: RAM write data.
- `ram_data_out` in DATA_SIZE: RAM read data. The RAM registers it one clock after `ram_cs & ram_re & ram_oe`.

## Operation

- State:
  - `wr_ptr` and `rd_ptr` are ADDR_SIZE+1 bits each. The low ADDR_SIZE bits are the RAM address; the MSB is the wrap bit.
  - `rd_valid` is a registered bit.
  - `overflow` and `underflow` are registered bits.
- Accept rules:
  - push_ok = `wr_en & ~full`.
  - pop_ok = `rd_en & ~empty`.
  - Evaluation uses the pre-edge flags.
- RAM drive is combinational from the current state and requests:
  - `ram_we` = push_ok.
  - `ram_re` = `ram_oe` = pop_ok.
  - `ram_cs` = push_ok | pop_ok.
  - `ram_wr_address` = `wr_ptr[ADDR_SIZE-1:0]`.
  - `ram_rd_address` = `rd_ptr[ADDR_SIZE-1:0]`.
  - `ram_data_in` = `wr_data`.
- Pointer update on each edge:
  - `wr_ptr` += 1 if push_ok.
  - `rd_ptr` += 1 if pop_ok.
  - Increments are modulo 2**(ADDR_SIZE+1).
- Flags are decoded combinationally from the registered pointers:
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, modulo 2**(ADDR_SIZE+1).
  - `almost_full` = `count >= AFULL_LVL`.
- Errors:
  - `overflow` sets on `wr_en & full`.
  - `underflow` sets on `rd_en & empty`.
  - Both clear on `clr_err`. When clear and set occur in the same cycle, set wins.
  - A rejected push or pop does not change the pointers or the RAM.
- Simultaneous push and pop:
  - When neither is blocked, both proceed and `count` is unchanged.
  - When full, only the pop proceeds.
  - When empty, only the push proceeds. The pushed word is poppable from the next cycle; there is no fall-through.
- Collisions: read and write never target the same address in one cycle, because empty blocks the pop and full blocks the push. No bypass logic is required.

## Timing

- Reset values, asserted asynchronously:
  - `wr_ptr` = `rd_ptr` = 0, so `count` = 0.
  - `empty` = 1; `full` = 0; `almost_full` = 0.
  - `rd_valid` = 0; `overflow` = `underflow` = 0.
  - RAM controls are 0.
  - RAM contents are not cleared.
- Reset mid-operation: pointers return to 0 and all buffered words are discarded. A pending `rd_valid` is dropped.
- Write latency: a word pushed at edge N is in the RAM after edge N. It can be popped starting in cycle N+1.
- Read latency is 1:
  - pop_ok in cycle N gives `rd_valid` = 1 in cycle N+1, with `rd_data` = word at the popped address.
  - Back-to-back pops give `rd_valid` high on consecutive cycles.
- Flag latency: `full`, `empty`, `count` and `almost_full` reflect an accepted operation in the cycle after the edge.
- Wrap: after DEPTH pushes the address returns to 0 and the wrap bit toggles. The FIFO operates indefinitely.

## Test plan

- Reset, then 16 pushes of values 1..16 at addresses 0..15, then `wr_en` with `wr_data` = 99:
  - `full` = 1 and `count` = 16.
  - `almost_full` rose when `count` reached 12.
  - The 17th push is rejected: `overflow` = 1, `ram_we` = 0.
- From full, 16 consecutive pops: `rd_data` = 1..16 on 16 consecutive `rd_valid` cycles, then `empty` = 1. One more pop sets `underflow`, and `rd_valid` stays 0.
- With `count` = 5, push and pop every cycle for 40 cycles:
  - `count` stays at 5.
  - Both addresses wrap past 15 to 0.
  - Output order matches input order.
- Push and pop in the same cycle:
  - When empty, only the push is accepted; the word pops in the next cycle with `rd_valid` 2 cycles after the push.
  - When full, only the pop is accepted and `count` becomes 15.
- Assert `rst_n` low asynchronously between edges with `count` = 7 and a pop in flight: all outputs take their reset values immediately and no `rd_valid` follows. After `rst_n` returns high, a push of 0xA5 followed by a pop returns 0xA5.
- `clr_err` pulse with `overflow` = 1: `overflow` = 0 on the next cycle. `clr_err` together with a new push while full: `overflow` stays 1.
